// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial, LSB-first subtractor: diff = a - b (mod 2^WIDTH), one
//   full-subtractor cell per clock plus a registered borrow. Operands enter
//   through a valid/ready handshake; the result leaves the same way and is
//   held in DONE until the consumer takes it.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for operands, in_ready=1
//   SHIFT | one bit per edge, WIDTH edges, borrow carried in br_q
//   DONE  | out_valid=1, result held until out_ready
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready only in IDLE, 0 in reset)
//   a, b              minuend / subtrahend, sampled at the acceptance edge
//   out_valid/out_ready result handshake
//   diff              a - b mod 2^WIDTH
//   borrow_out        unsigned a < b
//   ovf               signed overflow of a - b
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] d_sr_q, d_sr_d;
   logic             br_q, br_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;

   logic             bit_x, bit_y, bit_d, br_next;

   // Full-subtractor cell on the current LSBs.
   always_comb begin
      bit_x   = a_sr_q[0];
      bit_y   = b_sr_q[0];
      bit_d   = bit_x ^ bit_y ^ br_q;
      br_next = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & br_q);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      d_sr_d   = d_sr_q;
      br_d     = br_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_sr_d  = a;
               b_sr_d  = b;
               d_sr_d  = '0;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            d_sr_d = {bit_d, d_sr_q[WIDTH-1:1]};
            br_d   = br_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               // Final bit goes straight into the result register so the
               // answer is complete on the same edge that enters DONE.
               diff_d   = {bit_d, d_sr_q[WIDTH-1:1]};
               borrow_d = br_next;
               ovf_d    = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
               cnt_d    = '0;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         d_sr_q   <= '0;
         br_q     <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         d_sr_q   <= d_sr_d;
         br_q     <= br_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE) && !rst;
   assign out_valid  = (state_q == S_DONE);
   assign diff       = diff_q;
   assign borrow_out = borrow_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready;
   logic         in_ready, out_valid, borrow_out, ovf;
   logic [W-1:0] a, b, diff;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] d;
      logic       br;
      logic       ov;
      int         acc;
   } exp_t;
   exp_t q[$];
   exp_t e;

   task automatic chk1(input string name, input logic act, input logic expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic chk32(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Monitor: latency on rising out_valid, stability while stalled,
   // result compare on handshake.
   logic       prev_v = 1'b0;
   logic [7:0] prev_d;
   logic       prev_br, prev_ov;
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (out_valid) begin
            if (!prev_v) begin
               if (q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
               end else begin
                  chk32("latency", cyc, q[0].acc + W);
               end
            end else begin
               chk8("hold_diff", diff, prev_d);
               chk1("hold_borrow", borrow_out, prev_br);
               chk1("hold_ovf", ovf, prev_ov);
            end
            if (out_ready && q.size() > 0) begin
               e = q.pop_front();
               chk8("diff", diff, e.d);
               chk1("borrow_out", borrow_out, e.br);
               chk1("ovf", ovf, e.ov);
            end
         end
         prev_v  = out_valid;
         prev_d  = diff;
         prev_br = borrow_out;
         prev_ov = ovf;
      end
   end

   task automatic accept(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic eo);
      int g = 0;
      while (!in_ready && g < 50) begin
         @(posedge clk); #1;
         g++;
      end
      chk1("in_ready_before_op", in_ready, 1'b1);
      a = av;
      b = bv;
      in_valid = 1'b1;
      @(posedge clk); #1;
      q.push_back('{ed, eb, eo, cyc});
      in_valid = 1'b0;
   endtask

   // Busy time: operands and in_valid scrambled every cycle until DONE.
   task automatic wait_done();
      int g = 0;
      while (!out_valid && g < 50) begin
         a = 8'($urandom);
         b = 8'($urandom);
         in_valid = 1'($urandom);
         @(posedge clk); #1;
         g++;
      end
      in_valid = 1'b0;
      chk1("out_valid_seen", out_valid, 1'b1);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk1("idle_after_accept", in_ready, 1'b1);
      chk1("out_valid_cleared", out_valid, 1'b0);
   endtask

   task automatic op(input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb, input logic eo,
                     input int stall);
      accept(av, bv, ed, eb, eo);
      wait_done();
      repeat (stall) begin
         @(posedge clk); #1;
      end
      release_out();
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       br;
      logic       ov;
   } vec_t;

   vec_t dirv[7] = '{
      '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0},
      '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0},
      '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1},
      '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1},
      '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0},
      '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0},
      '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0}
   };

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       quiet;
      logic [7:0] ra, rb, rd;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk1("reset_in_ready", in_ready, 1'b0);
      chk1("reset_out_valid", out_valid, 1'b0);
      chk8("reset_diff", diff, 8'h00);
      chk1("reset_borrow", borrow_out, 1'b0);
      chk1("reset_ovf", ovf, 1'b0);
      rst = 1'b0;
      #1;
      chk1("post_reset_in_ready", in_ready, 1'b1);

      foreach (dirv[i])
         op(dirv[i].a, dirv[i].b, dirv[i].d, dirv[i].br, dirv[i].ov, 0);

      // Backpressure with a competing operand offer during DONE.
      accept(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
      wait_done();
      a = 8'h01;
      b = 8'h01;
      in_valid = 1'b1;
      repeat (5) begin
         chk1("bp_in_ready", in_ready, 1'b0);
         chk1("bp_out_valid", out_valid, 1'b1);
         @(posedge clk); #1;
      end
      chk8("bp_diff", diff, 8'h37);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk1("bp_idle_in_ready", in_ready, 1'b1);
      chk1("bp_idle_out_valid", out_valid, 1'b0);
      quiet = 1'b1;
      repeat (W + 3) begin
         @(posedge clk); #1;
         if (out_valid) quiet = 1'b0;
      end
      chk1("bp_offer_not_captured", quiet, 1'b1);

      // Reset at the 4th SHIFT edge.
      accept(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk1("rst_forces_in_ready_low", in_ready, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      #1;
      chk1("abort_out_valid", out_valid, 1'b0);
      chk8("abort_diff", diff, 8'h00);
      chk1("abort_borrow", borrow_out, 1'b0);
      chk1("abort_ovf", ovf, 1'b0);
      chk1("abort_in_ready", in_ready, 1'b1);
      quiet = 1'b1;
      repeat (W + 2) begin
         @(posedge clk); #1;
         if (out_valid) quiet = 1'b0;
      end
      chk1("abort_no_out_valid", quiet, 1'b1);
      op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0);

      // Random operands with random stalls against a reference model.
      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rd = ra - rb;
         op(ra, rb, rd, ra < rb, (ra[7] != rb[7]) && (rd[7] != ra[7]),
            int'($urandom_range(0, 3)));
      end

      repeat (2) @(posedge clk);
      #1;
      chk32("scoreboard_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
